adc_spi_responder: RTL and testbench

//  Synthesizable SPI slave emulating the 8-channel 12-bit serial ADC read by ADC_CTRL (ADC_CS_N/ADC_SCLK/ADC_SADDR/ADC_SDAT).

---
 rtl/adc_spi_responder.sv | 235 +++++++++++++++++++++++
 tb/tb_adc_spi_responder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/adc_spi_responder.sv
// SPI slave that stands in for the 8-channel 12-bit serial ADC on the ADC_CTRL pins.
// It returns register-supplied channel samples to the master in 16-bit frames (4 zeros + sample).
module adc_spi_responder #(
    parameter int NUM_CH      = 8,
    parameter int DATA_W      = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     c50m,
    input  logic                     rst_n,
    input  logic                     cs_n,
    input  logic                     sclk,
    input  logic                     din,
    output logic                     dout,
    output logic                     dout_oe,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    output logic [2:0]               next_addr,
    output logic                     frame_done,
    output logic                     frame_error
);

    localparam int FRAME_W = DATA_W + 4;
    localparam int CNT_W   = $clog2(FRAME_W);

    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] RISE_A2   = CNT_W'(2);
    localparam logic [CNT_W-1:0] RISE_A1   = CNT_W'(3);
    localparam logic [CNT_W-1:0] RISE_A0   = CNT_W'(4);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    // Selects one channel sample; channels beyond NUM_CH read as zero.
    function automatic logic [DATA_W-1:0] pick_ch(input logic [NUM_CH*DATA_W-1:0] data,
                                                  input logic [2:0]               ch);
        logic [DATA_W-1:0] sample;
        sample = {DATA_W{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch == 3'(i)) begin
                sample = data[i*DATA_W +: DATA_W];
            end else begin
                sample = sample;
            end
        end
        return sample;
    endfunction

    logic [SYNC_STAGES-1:0] cs_sync_r;
    logic [SYNC_STAGES-1:0] sclk_sync_r;
    logic [SYNC_STAGES-1:0] din_sync_r;
    logic                   cs_prev_r;
    logic                   sclk_prev_r;
    logic [SYNC_STAGES:0]   settle_r;
    logic                   armed_r;

    logic                   cs_s;
    logic                   sclk_s;
    logic                   din_s;
    logic                   cs_fall_s;
    logic                   cs_rise_s;
    logic                   sclk_rise_s;
    logic                   sclk_fall_s;
    logic [FRAME_W-1:0]     load_word_s;

    state_t                 state_r;
    state_t                 state_n;
    logic [FRAME_W-1:0]     shreg_r;
    logic [FRAME_W-1:0]     shreg_n;
    logic [CNT_W-1:0]       rise_cnt_r;
    logic [CNT_W-1:0]       rise_cnt_n;
    logic [CNT_W-1:0]       fall_cnt_r;
    logic [CNT_W-1:0]       fall_cnt_n;
    logic [2:0]             addr_r;
    logic [2:0]             addr_n;
    logic [2:0]             next_addr_r;
    logic [2:0]             next_addr_n;
    logic                   dout_r;
    logic                   dout_n;
    logic                   dout_oe_r;
    logic                   dout_oe_n;
    logic                   frame_done_r;
    logic                   frame_done_n;
    logic                   frame_error_r;
    logic                   frame_error_n;

    // Pin synchronizers and edge-detect flops, preset to the idle bus levels.
    always_ff @(posedge c50m or negedge rst_n) begin
        if (!rst_n) begin
            cs_sync_r   <= {SYNC_STAGES{1'b1}};
            sclk_sync_r <= {SYNC_STAGES{1'b1}};
            din_sync_r  <= {SYNC_STAGES{1'b0}};
            cs_prev_r   <= 1'b1;
            sclk_prev_r <= 1'b1;
        end else begin
            cs_sync_r   <= SYNC_STAGES'({cs_sync_r, cs_n});
            sclk_sync_r <= SYNC_STAGES'({sclk_sync_r, sclk});
            din_sync_r  <= SYNC_STAGES'({din_sync_r, din});
            cs_prev_r   <= cs_s;
            sclk_prev_r <= sclk_s;
        end
    end

    // Arm frame starts only after a real, deasserted cs_n has been seen out of reset,
    // so a cs_n held low across reset release cannot fake a falling edge.
    always_ff @(posedge c50m or negedge rst_n) begin
        if (!rst_n) begin
            settle_r <= {(SYNC_STAGES+1){1'b0}};
            armed_r  <= 1'b0;
        end else begin
            settle_r <= (SYNC_STAGES+1)'({settle_r, 1'b1});
            armed_r  <= armed_r | (settle_r[SYNC_STAGES] & cs_s);
        end
    end

    assign cs_s        = cs_sync_r[SYNC_STAGES-1];
    assign sclk_s      = sclk_sync_r[SYNC_STAGES-1];
    assign din_s       = din_sync_r[SYNC_STAGES-1];
    assign cs_fall_s   = cs_prev_r & ~cs_s & armed_r;
    assign cs_rise_s   = ~cs_prev_r & cs_s;
    assign sclk_rise_s = ~sclk_prev_r & sclk_s;
    assign sclk_fall_s = sclk_prev_r & ~sclk_s;
    assign load_word_s = {4'b0000, pick_ch(ch_data, next_addr_r)};

    // Frame FSM and shifter: next-state, counters and output values.
    always_comb begin
        state_n       = state_r;
        shreg_n       = shreg_r;
        rise_cnt_n    = rise_cnt_r;
        fall_cnt_n    = fall_cnt_r;
        addr_n        = addr_r;
        next_addr_n   = next_addr_r;
        frame_done_n  = 1'b0;
        frame_error_n = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cs_fall_s) begin
                    state_n    = ST_ACTIVE;
                    shreg_n    = load_word_s;
                    rise_cnt_n = CNT_ZERO;
                    fall_cnt_n = CNT_ZERO;
                    addr_n     = 3'b000;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (cs_rise_s) begin
                    state_n       = ST_IDLE;
                    frame_error_n = (rise_cnt_r != CNT_ZERO) || (fall_cnt_r != CNT_ZERO);
                    rise_cnt_n    = CNT_ZERO;
                    fall_cnt_n    = CNT_ZERO;
                    addr_n        = 3'b000;
                end else if (sclk_rise_s) begin
                    if (rise_cnt_r == RISE_A2) begin
                        addr_n[2] = din_s;
                    end else if (rise_cnt_r == RISE_A1) begin
                        addr_n[1] = din_s;
                    end else if (rise_cnt_r == RISE_A0) begin
                        addr_n[0] = din_s;
                    end else begin
                        addr_n = addr_r;
                    end
                    if (rise_cnt_r == CNT_LAST) begin
                        rise_cnt_n   = CNT_ZERO;
                        next_addr_n  = addr_r;
                        frame_done_n = 1'b1;
                    end else begin
                        rise_cnt_n = rise_cnt_r + CNT_ONE;
                    end
                end else if (sclk_fall_s) begin
                    // The last fall of a frame reloads, so back-to-back frames use the fresh address.
                    if (fall_cnt_r == CNT_LAST) begin
                        shreg_n    = load_word_s;
                        fall_cnt_n = CNT_ZERO;
                    end else begin
                        shreg_n    = {shreg_r[FRAME_W-2:0], 1'b0};
                        fall_cnt_n = fall_cnt_r + CNT_ONE;
                    end
                end else begin
                    state_n = ST_ACTIVE;
                end
            end
            default: begin
                state_n    = ST_IDLE;
                rise_cnt_n = CNT_ZERO;
                fall_cnt_n = CNT_ZERO;
                addr_n     = 3'b000;
            end
        endcase
        if (state_n == ST_ACTIVE) begin
            dout_n    = shreg_n[FRAME_W-1];
            dout_oe_n = 1'b1;
        end else begin
            dout_n    = 1'b0;
            dout_oe_n = 1'b0;
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge c50m or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            shreg_r       <= {FRAME_W{1'b0}};
            rise_cnt_r    <= CNT_ZERO;
            fall_cnt_r    <= CNT_ZERO;
            addr_r        <= 3'b000;
            next_addr_r   <= 3'b000;
            dout_r        <= 1'b0;
            dout_oe_r     <= 1'b0;
            frame_done_r  <= 1'b0;
            frame_error_r <= 1'b0;
        end else begin
            state_r       <= state_n;
            shreg_r       <= shreg_n;
            rise_cnt_r    <= rise_cnt_n;
            fall_cnt_r    <= fall_cnt_n;
            addr_r        <= addr_n;
            next_addr_r   <= next_addr_n;
            dout_r        <= dout_n;
            dout_oe_r     <= dout_oe_n;
            frame_done_r  <= frame_done_n;
            frame_error_r <= frame_error_n;
        end
    end

    assign dout        = dout_r;
    assign dout_oe     = dout_oe_r;
    assign next_addr   = next_addr_r;
    assign frame_done  = frame_done_r;
    assign frame_error = frame_error_r;

endmodule

// File: tb/tb_adc_spi_responder.sv
// Self-checking bench for adc_spi_responder: an SPI master model drives frames and a
// frame-level reference (served channel = address of the previous completed frame) predicts results.
module tb_adc_spi_responder;

    localparam int NUM_CH = 8;
    localparam int DATA_W = 12;

    logic                     c50m = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     cs_n = 1'b1;
    logic                     sclk = 1'b1;
    logic                     din = 1'b0;
    logic                     dout;
    logic                     dout_oe;
    logic [NUM_CH*DATA_W-1:0] ch_data;
    logic [2:0]               next_addr;
    logic                     frame_done;
    logic                     frame_error;

    logic [DATA_W-1:0] ch_val [NUM_CH];

    int total = 0;
    int bad = 0;
    int done_seen = 0;
    int err_seen = 0;
    int exp_done = 0;
    int exp_err = 0;
    logic [2:0]  model_next = 3'd0;
    int          cur_ch = 0;
    logic [15:0] exp_word = 16'h0000;

    adc_spi_responder #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .SYNC_STAGES(2)) dut (
        .c50m        (c50m),
        .rst_n       (rst_n),
        .cs_n        (cs_n),
        .sclk        (sclk),
        .din         (din),
        .dout        (dout),
        .dout_oe     (dout_oe),
        .ch_data     (ch_data),
        .next_addr   (next_addr),
        .frame_done  (frame_done),
        .frame_error (frame_error)
    );

    always #10 c50m = ~c50m;

    always_comb begin
        ch_data = {(NUM_CH*DATA_W){1'b0}};
        for (int i = 0; i < NUM_CH; i++) ch_data[i*DATA_W +: DATA_W] = ch_val[i];
    end

    always @(negedge c50m) begin
        if (frame_done === 1'b1) done_seen <= done_seen + 1;
        if (frame_error === 1'b1) err_seen <= err_seen + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge c50m);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // A frame snapshots the channel addressed by the previous completed frame.
    task automatic model_load();
        cur_ch   = int'(model_next);
        exp_word = {4'b0000, ch_val[model_next]};
    endtask

    task automatic run_frame(input string tag, input logic [2:0] addr, input int nsclk,
                             input bit start_cs, input bit end_cs, input int chg_at);
        logic [15:0] word;
        logic [15:0] want;
        int lo;
        int hi;
        word = 16'h0000;
        if (start_cs) begin
            sclk = 1'b0;
            tick(6);
            cs_n = 1'b0;
            model_load();
            tick(6);
            check({tag, "_oe_start"}, 32'(dout_oe), 32'd1);
        end
        want = exp_word;
        for (int k = 1; k <= nsclk; k++) begin
            lo = int'($urandom_range(4, 7));
            hi = int'($urandom_range(4, 7));
            if (k == 3)      din = addr[2];
            else if (k == 4) din = addr[1];
            else if (k == 5) din = addr[0];
            else             din = 1'($urandom_range(0, 1));
            tick(lo);
            word = {word[14:0], dout};
            sclk = 1'b1;
            tick(hi);
            sclk = 1'b0;
            if (k == chg_at) ch_val[cur_ch] = ch_val[cur_ch] ^ 12'($urandom_range(1, 4095));
            if (k == 16) begin
                model_next = addr;
                exp_done++;
                model_load();
            end
        end
        tick(5);
        if (nsclk == 16) check({tag, "_word"}, 32'(word), 32'(want));
        else if (nsclk > 0) check({tag, "_partial"}, 32'(word), 32'(want >> (16 - nsclk)));
        check({tag, "_next_addr"}, 32'(next_addr), 32'(model_next));
        check({tag, "_done_cnt"}, 32'(done_seen), 32'(exp_done));
        if (end_cs) begin
            cs_n = 1'b1;
            if (nsclk != 0 && nsclk != 16) exp_err++;
            tick(6);
            check({tag, "_dout_end"}, 32'(dout), 32'd0);
            check({tag, "_oe_end"}, 32'(dout_oe), 32'd0);
            check({tag, "_err_cnt"}, 32'(err_seen), 32'(exp_err));
            check({tag, "_next_addr_end"}, 32'(next_addr), 32'(model_next));
            sclk = 1'b1;
            tick(6);
        end else begin
            check({tag, "_oe_mid"}, 32'(dout_oe), 32'd1);
            check({tag, "_err_cnt"}, 32'(err_seen), 32'(exp_err));
        end
    endtask

    initial begin
        bit in_frame;
        bit start;
        bit stop;
        int ns;
        int chg;
        for (int i = 0; i < NUM_CH; i++) ch_val[i] = 12'($urandom_range(0, 4095));
        ch_val[0] = 12'hABC;

        // Reset state
        tick(3);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_oe", 32'(dout_oe), 32'd0);
        check("rst_next_addr", 32'(next_addr), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        check("rst_err", 32'(frame_error), 32'd0);
        rst_n = 1'b1;
        tick(8);

        // 1: single frame from ch0
        run_frame("t1", 3'd0, 16, 1'b1, 1'b1, 0);
        check("t1_literal", 32'(exp_word), 32'h0ABC);

        // 2: address 5 selects ch5 in the following frame
        ch_val[5] = 12'h5A5;
        run_frame("t2a", 3'd5, 16, 1'b1, 1'b1, 0);
        run_frame("t2b", 3'd0, 16, 1'b1, 1'b1, 0);

        // 3: back-to-back frames under one chip select
        ch_val[2] = 12'h222;
        ch_val[7] = 12'h777;
        run_frame("t3a", 3'd2, 16, 1'b1, 1'b0, 0);
        run_frame("t3b", 3'd7, 16, 1'b0, 1'b0, 0);
        run_frame("t3c", 3'd0, 16, 1'b0, 1'b1, 0);

        // 4: chip select aborts after 9 clocks
        run_frame("t4", 3'd3, 9, 1'b1, 1'b1, 0);

        // 6: sample change mid-frame is only seen next frame
        run_frame("t6a", 3'd0, 16, 1'b1, 1'b1, 8);
        run_frame("t6b", 3'd0, 16, 1'b1, 1'b1, 0);

        // 5: reset mid-frame, then clocks with cs_n still low are ignored
        run_frame("t5pre", 3'd6, 16, 1'b1, 1'b1, 0);
        run_frame("t5", 3'd3, 6, 1'b1, 1'b0, 0);
        rst_n = 1'b0;
        #1;
        check("t5_rst_dout", 32'(dout), 32'd0);
        check("t5_rst_oe", 32'(dout_oe), 32'd0);
        check("t5_rst_next_addr", 32'(next_addr), 32'd0);
        model_next = 3'd0;
        tick(3);
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            sclk = ~sclk;
            tick(5);
        end
        check("t5_ignored_oe", 32'(dout_oe), 32'd0);
        check("t5_ignored_done", 32'(done_seen), 32'(exp_done));
        check("t5_ignored_err", 32'(err_seen), 32'(exp_err));
        sclk = 1'b1;
        cs_n = 1'b1;
        tick(8);
        run_frame("t5post", 3'd1, 16, 1'b1, 1'b1, 0);

        // Randomized frames
        in_frame = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (!in_frame) begin
                for (int i = 0; i < NUM_CH; i++) ch_val[i] = 12'($urandom_range(0, 4095));
            end
            start = !in_frame;
            ns = 16;
            if (start && ($urandom_range(0, 3) == 0)) ns = int'($urandom_range(0, 15));
            stop = (ns != 16) || ($urandom_range(0, 2) == 0) || (n == 39);
            chg = ($urandom_range(0, 1) == 1) ? int'($urandom_range(6, 12)) : 0;
            run_frame("rnd", 3'($urandom_range(0, 7)), ns, start, stop, chg);
            in_frame = !stop;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
